// File: rtl/simple_uart_pkg.sv
// Shared constants, state encoding and divisor helper for the simple_uart TX/RX blocks.
package simple_uart_pkg;

    localparam int NUM_BITS = 8;
    localparam int STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    function automatic int divisor(input int system_freq, input int baud_rate);
        return system_freq / baud_rate;
    endfunction

endpackage

// File: rtl/simple_uart_baud_gen.sv
// Bit-period counter: restarts on request, one-cycle tick on the last cycle of each bit.
module simple_uart_baud_gen #(
    parameter int DIVISOR = 5208
) (
    input  logic                       clock,
    input  logic                       arst_n,
    input  logic                       restart,
    output logic                       tick,
    output logic [$clog2(DIVISOR)-1:0] count
);

    localparam int             CW   = $clog2(DIVISOR);
    localparam logic [CW-1:0]  LAST = CW'(DIVISOR - 1);

    assign tick = (count == LAST);

    // Wrapping on tick makes every bit boundary a restart without help from the caller.
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n)
            count <= '0;
        else if (restart || tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/simple_uart_tx.sv
// 8N1 UART transmitter with valid/ready input; define SIMPLE_UART_TX_PARITY_EN for an even-parity bit.
module simple_uart_tx
    import simple_uart_pkg::*;
#(
    parameter int SYSTEM_FREQ = 50_000_000,
    parameter int BAUD_RATE   = 9600
) (
    input  logic       clock,
    input  logic       arst_n,
    input  logic [7:0] tx_value,
    input  logic       tx_value_valid,
    output logic       tx_value_ready,
    output logic       tx_bit,
    output logic       tx_busy
);

    localparam int            DIVISOR  = divisor(SYSTEM_FREQ, BAUD_RATE);
    localparam int            CW       = $clog2(DIVISOR);
    localparam int            BCW      = $clog2(NUM_BITS);
    localparam logic [CW-1:0] PRE_LAST = CW'(DIVISOR - 2);

    if (DIVISOR < 4) begin : g_bad_divisor
        $fatal(1, "simple_uart_tx: DIVISOR must be at least 4");
    end

    uart_state_t         state, state_next;
    logic [NUM_BITS-1:0] shift, shift_next;
    logic [BCW-1:0]      bit_cnt, bit_cnt_next;
    logic                tx_bit_next, ready_next, busy_next;
    logic                restart, tick;
    logic [CW-1:0]       count;
    logic                accept;
`ifdef SIMPLE_UART_TX_PARITY_EN
    logic                parity, parity_next;
`endif

    assign accept = tx_value_valid & tx_value_ready;

    simple_uart_baud_gen #(.DIVISOR(DIVISOR)) u_baud (
        .clock   (clock),
        .arst_n  (arst_n),
        .restart (restart),
        .tick    (tick),
        .count   (count)
    );

    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_cnt_next = bit_cnt;
        tx_bit_next  = tx_bit;
        ready_next   = 1'b0;
        busy_next    = tx_busy;
        restart      = 1'b0;
`ifdef SIMPLE_UART_TX_PARITY_EN
        parity_next  = parity;
`endif
        unique case (state)
            IDLE: begin
                restart     = 1'b1;
                tx_bit_next = 1'b1;
                busy_next   = 1'b0;
                ready_next  = 1'b1;
                if (accept) begin
                    state_next  = START;
                    shift_next  = tx_value;
                    tx_bit_next = 1'b0;
                    busy_next   = 1'b1;
                    ready_next  = 1'b0;
`ifdef SIMPLE_UART_TX_PARITY_EN
                    parity_next = ^tx_value;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                    tx_bit_next  = shift[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next   = shift >> 1;
                    bit_cnt_next = bit_cnt + 1'b1;
                    if (bit_cnt == BCW'(NUM_BITS - 1)) begin
`ifdef SIMPLE_UART_TX_PARITY_EN
                        state_next  = PARITY;
                        tx_bit_next = parity;
`else
                        state_next  = STOP;
                        tx_bit_next = 1'b1;
`endif
                    end else begin
                        tx_bit_next = shift[1];
                    end
                end
            end
`ifdef SIMPLE_UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_next  = STOP;
                    tx_bit_next = 1'b1;
                end
            end
`endif
            STOP: begin
                // Ready is raised one cycle early so it is visible during the final stop cycle.
                ready_next = (count == PRE_LAST);
                if (tick) begin
                    if (accept) begin
                        state_next  = START;
                        shift_next  = tx_value;
                        tx_bit_next = 1'b0;
`ifdef SIMPLE_UART_TX_PARITY_EN
                        parity_next = ^tx_value;
`endif
                    end else begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        ready_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next  = IDLE;
                tx_bit_next = 1'b1;
                busy_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            state          <= IDLE;
            shift          <= '0;
            bit_cnt        <= '0;
            tx_bit         <= 1'b1;
            tx_value_ready <= 1'b0;
            tx_busy        <= 1'b0;
`ifdef SIMPLE_UART_TX_PARITY_EN
            parity         <= 1'b0;
`endif
        end else begin
            state          <= state_next;
            shift          <= shift_next;
            bit_cnt        <= bit_cnt_next;
            tx_bit         <= tx_bit_next;
            tx_value_ready <= ready_next;
            tx_busy        <= busy_next;
`ifdef SIMPLE_UART_TX_PARITY_EN
            parity         <= parity_next;
`endif
        end
    end

endmodule
